// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl shared pipeline package.
// Memory map constants, sequencer state and npc source encodings.
package pc_seq_ctrl_pkg;

  localparam logic [31:0] MEM_TEXT_START = 32'h0000_3000;
  localparam logic [31:0] MEM_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] PC_STEP        = 32'd4;

  typedef enum logic {
    ST_RUN,
    ST_PEND
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_PEND,
    SEL_EXC,
    SEL_ERET
  } npc_sel_e;

  function automatic logic [31:0] pc_incr(
    input logic [31:0] pc
  );
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_redirect_latch.sv
// One-entry pending redirect register.
// Holds a branch target resolved during a stall.
module redirect_latch
  import pc_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_set,
  input  logic        i_clr,
  input  logic [31:0] i_target,
  output state_e      o_state,
  output logic [31:0] o_target
);

  state_e      r_state;
  logic [31:0] r_target;

  // clear beats set; set while pending overwrites the target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_target <= '0;
    end else if (i_clr) begin
      r_state  <= ST_RUN;
    end else if (i_set) begin
      r_state  <= ST_PEND;
      r_target <= i_target;
    end
  end

  assign o_state  = r_state;
  assign o_target = r_target;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencing controller for IF.
// Picks npc, drives PC enable, defers stalled redirects.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] TEXT_START = MEM_TEXT_START,
  parameter logic [31:0] EXC_VECTOR = MEM_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc_cur,
  input  logic        i_stall,
  input  logic        i_br_valid,
  input  logic [31:0] i_br_target,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  output logic        o_pc_en,
  output logic [31:0] o_npc,
  output logic        o_flush_if,
  output logic        o_pend_valid,
  output npc_sel_e    o_npc_sel
);

  state_e      w_state;
  logic [31:0] w_pend_target;
  logic        w_set;
  logic        w_clr;
  logic        w_pc_en;
  logic [31:0] w_npc;
  logic        w_flush;
  npc_sel_e    w_sel;

  redirect_latch u_latch (
    .clk      (clk),
    .reset    (reset),
    .i_set    (w_set),
    .i_clr    (w_clr),
    .i_target (i_br_target),
    .o_state  (w_state),
    .o_target (w_pend_target)
  );

  // source priority: exc > eret > pending > branch > sequential
  always_comb begin
    w_pc_en = 1'b0;
    w_npc   = pc_incr(i_pc_cur);
    w_flush = 1'b0;
    w_sel   = SEL_SEQ;
    w_set   = 1'b0;
    w_clr   = 1'b0;
    if (reset) begin
      w_npc = TEXT_START;
    end else if (i_exc_req) begin
      w_npc   = EXC_VECTOR;
      w_pc_en = 1'b1;
      w_flush = 1'b1;
      w_sel   = SEL_EXC;
      w_clr   = 1'b1;
    end else if (i_eret_req) begin
      w_npc   = i_epc;
      w_pc_en = 1'b1;
      w_flush = 1'b1;
      w_sel   = SEL_ERET;
      w_clr   = 1'b1;
    end else if (w_state == ST_PEND) begin
      w_npc = w_pend_target;
      w_sel = SEL_PEND;
      if (!i_stall) begin
        w_pc_en = 1'b1;
        w_clr   = 1'b1;
      end else begin
        w_set = i_br_valid;
      end
    end else if (i_br_valid) begin
      w_npc   = i_br_target;
      w_sel   = SEL_BR;
      w_pc_en = !i_stall;
      w_set   = i_stall;
    end else begin
      w_pc_en = !i_stall;
    end
  end

  assign o_pc_en      = w_pc_en;
  assign o_npc        = w_npc;
  assign o_flush_if   = w_flush;
  assign o_npc_sel    = w_sel;
  assign o_pend_valid = (w_state == ST_PEND);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl.
// Directed vectors, queue-based reference model, literal pins.
module tb_pc_seq_ctrl;
  import pc_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_cur = 32'h3000;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic        pc_en;
  logic [31:0] npc;
  logic        flush_if;
  logic        pend_valid;
  npc_sel_e    npc_sel;

  int n_tests = 0;
  int n_fail  = 0;

  pc_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_pc_cur     (pc_cur),
    .i_stall      (stall),
    .i_br_valid   (br_valid),
    .i_br_target  (br_target),
    .i_exc_req    (exc_req),
    .i_eret_req   (eret_req),
    .i_epc        (epc),
    .o_pc_en      (pc_en),
    .o_npc        (npc),
    .o_flush_if   (flush_if),
    .o_pend_valid (pend_valid),
    .o_npc_sel    (npc_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: pending redirect is a queue of at most one target
  logic [31:0] m_q[$];
  bit          m_known = 0;

  always @(negedge clk) begin
    logic        e_en;
    logic        e_fl;
    logic [31:0] e_npc;
    npc_sel_e    e_sel;
    e_en  = 0;
    e_fl  = 0;
    e_npc = '0;
    e_sel = SEL_SEQ;
    if (m_known)
      chk("m_pend_valid", {31'b0, pend_valid}, {31'b0, m_q.size() != 0});
    if (reset) begin
      e_npc = 32'h0000_3000;
      m_q.delete();
      m_known = 1;
    end else if (exc_req) begin
      e_en = 1; e_fl = 1; e_npc = 32'h0000_4180; e_sel = SEL_EXC;
      m_q.delete();
    end else if (eret_req) begin
      e_en = 1; e_fl = 1; e_npc = epc; e_sel = SEL_ERET;
      m_q.delete();
    end else if (m_q.size() != 0) begin
      if (!stall) begin
        e_en = 1; e_npc = m_q.pop_front(); e_sel = SEL_PEND;
      end else if (br_valid) begin
        m_q[0] = br_target;
      end
    end else if (br_valid) begin
      if (!stall) begin
        e_en = 1; e_npc = br_target; e_sel = SEL_BR;
      end else begin
        m_q.push_back(br_target);
      end
    end else begin
      e_en = !stall;
      e_npc = pc_cur + 32'd4;
    end
    chk("m_pc_en", {31'b0, pc_en}, {31'b0, e_en});
    chk("m_flush_if", {31'b0, flush_if}, {31'b0, e_fl});
    if (e_en || reset) chk("m_npc", npc, e_npc);
    if (e_en) chk("m_sel", {29'b0, npc_sel}, {29'b0, e_sel});
  end

  task automatic drv(input logic rst, input logic [31:0] pc,
                     input logic st, input logic br,
                     input logic [31:0] tgt, input logic ex,
                     input logic er, input logic [31:0] ep);
    reset = rst; pc_cur = pc; stall = st; br_valid = br;
    br_target = tgt; exc_req = ex; eret_req = er; epc = ep;
    #2;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    drv(1, 32'h3000, 0, 0, 0, 0, 0, 0);
    chk("rst_en", {31'b0, pc_en}, 32'd0);
    chk("rst_npc", npc, 32'h0000_3000);
    chk("rst_flush", {31'b0, flush_if}, 32'd0);
    nxt();
    drv(1, 32'h3000, 0, 0, 0, 0, 0, 0);
    nxt();
    chk("rst_pend", {31'b0, pend_valid}, 32'd0);

    // sequential and wrap
    drv(0, 32'h3000, 0, 0, 0, 0, 0, 0);
    chk("seq_npc", npc, 32'h0000_3004);
    chk("seq_en", {31'b0, pc_en}, 32'd1);
    nxt();
    drv(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    chk("wrap_npc", npc, 32'h0000_0000);
    nxt();
    drv(0, 32'h3008, 1, 0, 0, 0, 0, 0);
    chk("stall_en", {31'b0, pc_en}, 32'd0);
    nxt();

    // stalled branch held three cycles
    for (int i = 0; i < 3; i++) begin
      drv(0, 32'h3008, 1, 1, 32'h3100, 0, 0, 0);
      chk("sbr_en", {31'b0, pc_en}, 32'd0);
      if (i > 0) chk("sbr_pend", {31'b0, pend_valid}, 32'd1);
      nxt();
    end
    drv(0, 32'h3008, 0, 0, 0, 0, 0, 0);
    chk("rel_npc", npc, 32'h0000_3100);
    chk("rel_en", {31'b0, pc_en}, 32'd1);
    chk("rel_flush", {31'b0, flush_if}, 32'd0);
    nxt();
    drv(0, 32'h3100, 0, 0, 0, 0, 0, 0);
    chk("rel_pend0", {31'b0, pend_valid}, 32'd0);
    nxt();

    // unstalled branch
    drv(0, 32'h3104, 0, 1, 32'h3400, 0, 0, 0);
    chk("br_npc", npc, 32'h0000_3400);
    nxt();

    // exception overrides stall and pending
    drv(0, 32'h3400, 1, 1, 32'h3100, 0, 0, 0);
    nxt();
    drv(0, 32'h3400, 1, 0, 0, 1, 0, 0);
    chk("exc_npc", npc, 32'h0000_4180);
    chk("exc_en", {31'b0, pc_en}, 32'd1);
    chk("exc_flush", {31'b0, flush_if}, 32'd1);
    nxt();
    drv(0, 32'h4180, 1, 0, 0, 0, 0, 0);
    chk("exc_pend0", {31'b0, pend_valid}, 32'd0);
    nxt();
    drv(0, 32'h4180, 0, 0, 0, 0, 0, 0);
    chk("exc_noold", npc, 32'h0000_4184);
    nxt();

    // exc + eret, then eret alone
    drv(0, 32'h4184, 0, 0, 0, 1, 1, 32'h3008);
    chk("both_npc", npc, 32'h0000_4180);
    nxt();
    drv(0, 32'h4180, 0, 0, 0, 0, 1, 32'h3008);
    chk("eret_npc", npc, 32'h0000_3008);
    chk("eret_flush", {31'b0, flush_if}, 32'd1);
    nxt();

    // eret discards a pending redirect under stall
    drv(0, 32'h3008, 1, 1, 32'h3500, 0, 0, 0);
    nxt();
    drv(0, 32'h3008, 1, 0, 0, 0, 1, 32'h3010);
    chk("peret_npc", npc, 32'h0000_3010);
    nxt();
    drv(0, 32'h3010, 0, 0, 0, 0, 0, 0);
    chk("peret_seq", npc, 32'h0000_3014);
    nxt();

    // newest resolution overwrites pending target
    drv(0, 32'h3014, 1, 1, 32'h3600, 0, 0, 0);
    nxt();
    drv(0, 32'h3014, 1, 1, 32'h3700, 0, 0, 0);
    nxt();
    drv(0, 32'h3014, 0, 0, 0, 0, 0, 0);
    chk("ovw_npc", npc, 32'h0000_3700);
    nxt();

    // reset while pending
    drv(0, 32'h3700, 1, 1, 32'h3200, 0, 0, 0);
    nxt();
    drv(1, 32'h3700, 0, 0, 0, 0, 0, 0);
    chk("rpend_en", {31'b0, pc_en}, 32'd0);
    chk("rpend_npc", npc, 32'h0000_3000);
    nxt();
    drv(0, 32'h3000, 0, 0, 0, 0, 0, 0);
    chk("rpend_seq", npc, 32'h0000_3004);
    chk("rpend_pv", {31'b0, pend_valid}, 32'd0);
    nxt();
    drv(0, 32'h3004, 0, 0, 0, 0, 0, 0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
